// File: rtl/regbank_pkg.sv
// Shared constants and encodings for the register bank write path.
// Imported by the arbiter top and its round-robin sub-block.
package regbank_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_RUN,
    ST_CLEAR
  } state_t;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant with pointer update.
// Grants are one-hot and only issued while accept is high.
module rr_arbiter2 (
  input  logic clk,
  input  logic rst,
  input  logic accept,
  input  logic validA,
  input  logic validB,
  output logic grantA,
  output logic grantB
);
  import regbank_pkg::*;

  logic rrPtr;

  always_comb begin
    grantA = 1'b0;
    grantB = 1'b0;
    if (accept) begin
      unique case (1'b1)
        (validA && !validB): grantA = 1'b1;
        (!validA && validB): grantB = 1'b1;
        (validA && validB): begin
          grantA = (rrPtr == REQ_A);
          grantB = (rrPtr == REQ_B);
        end
        default: ;
      endcase
    end
  end

  // A grant always means a transfer, so the loser goes first next time.
  always_ff @(posedge clk) begin
    if (rst) begin
      rrPtr <= REQ_A;
    end else if (grantA) begin
      rrPtr <= REQ_B;
    end else if (grantB) begin
      rrPtr <= REQ_A;
    end
  end

endmodule

// File: rtl/regbank_write_arbiter.sv
// Owns the register bank write port: zero sweeps on reset or
// command, otherwise round-robin writeback from requesters A and B.
module regbank_write_arbiter #(
  parameter int DATA_W        = 8,
  parameter int ADDR_W        = 3,
  parameter int NUM_REGS      = 8,
  parameter int INIT_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              validA,
  input  logic [ADDR_W-1:0] regA,
  input  logic [DATA_W-1:0] dataA,
  output logic              readyA,
  input  logic              validB,
  input  logic [ADDR_W-1:0] regB,
  input  logic [DATA_W-1:0] dataB,
  output logic              readyB,
  input  logic              clearReq,
  output logic              busy,
  output logic              regWrite,
  output logic [ADDR_W-1:0] writeRegister,
  output logic [DATA_W-1:0] writeData
);
  import regbank_pkg::*;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);
  localparam state_t RST_ST =
    (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;

  state_t            state;
  state_t            stateNext;
  logic [ADDR_W-1:0] sweepCnt;
  logic [ADDR_W-1:0] sweepCntNext;
  logic              wrEnNext;
  logic [ADDR_W-1:0] wrRegNext;
  logic [DATA_W-1:0] wrDataNext;
  logic              accept;
  logic              grantA;
  logic              grantB;

  assign accept = !rst && (state == ST_RUN) && !clearReq;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .accept (accept),
    .validA (validA),
    .validB (validB),
    .grantA (grantA),
    .grantB (grantB)
  );

  assign readyA = grantA;
  assign readyB = grantB;
  assign busy   = rst ? (INIT_ON_RESET != 0)
                      : (state != ST_RUN);

  always_comb begin
    stateNext    = state;
    sweepCntNext = sweepCnt;
    wrEnNext     = 1'b0;
    wrRegNext    = writeRegister;
    wrDataNext   = writeData;
    unique case (state)
      ST_INIT, ST_CLEAR: begin
        wrEnNext     = 1'b1;
        wrRegNext    = sweepCnt;
        wrDataNext   = '0;
        sweepCntNext = sweepCnt + ADDR_W'(1);
        if (sweepCnt == LAST) begin
          stateNext    = ST_RUN;
          sweepCntNext = '0;
        end
      end
      ST_RUN: begin
        unique case (1'b1)
          clearReq: begin
            stateNext    = ST_CLEAR;
            sweepCntNext = '0;
          end
          grantA: begin
            wrEnNext   = 1'b1;
            wrRegNext  = regA;
            wrDataNext = dataA;
          end
          grantB: begin
            wrEnNext   = 1'b1;
            wrRegNext  = regB;
            wrDataNext = dataB;
          end
          default: ;
        endcase
      end
      default: stateNext = RST_ST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RST_ST;
      sweepCnt      <= '0;
      regWrite      <= 1'b0;
      writeRegister <= '0;
      writeData     <= '0;
    end else begin
      state         <= stateNext;
      sweepCnt      <= sweepCntNext;
      regWrite      <= wrEnNext;
      writeRegister <= wrRegNext;
      writeData     <= wrDataNext;
    end
  end

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Scoreboard bench: a cycle-level reference model queues expected
// bank writes, a monitor pops them as the DUT writes.
module tb_regbank_write_arbiter;
  import regbank_pkg::*;

  localparam int NR = 8;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, validA, validB, clearReq;
  logic [2:0] regA, regB;
  logic [7:0] dataA, dataB;
  logic       readyA, readyB, busy, regWrite;
  logic [2:0] writeRegister;
  logic [7:0] writeData;

  logic       rst2, validA2;
  logic [2:0] regA2;
  logic [7:0] dataA2;
  logic       readyA2, readyB2, busy2, regWrite2;
  logic [2:0] writeRegister2;
  logic [7:0] writeData2;

  regbank_write_arbiter dut (
    .clk(clk), .rst(rst),
    .validA(validA), .regA(regA), .dataA(dataA),
    .readyA(readyA),
    .validB(validB), .regB(regB), .dataB(dataB),
    .readyB(readyB),
    .clearReq(clearReq), .busy(busy),
    .regWrite(regWrite),
    .writeRegister(writeRegister),
    .writeData(writeData)
  );

  regbank_write_arbiter #(.INIT_ON_RESET(0)) dut2 (
    .clk(clk), .rst(rst2),
    .validA(validA2), .regA(regA2), .dataA(dataA2),
    .readyA(readyA2),
    .validB(1'b0), .regB(3'd0), .dataB(8'd0),
    .readyB(readyB2),
    .clearReq(1'b0), .busy(busy2),
    .regWrite(regWrite2),
    .writeRegister(writeRegister2),
    .writeData(writeData2)
  );

  int          nChecks = 0;
  int          nPass = 0;
  int          nWrites = 0;
  logic [10:0] expQ[$];
  logic [10:0] expW;
  logic [7:0]  bank[NR];

  int   sweepLeft = 0;
  int   sweepIdx = 0;
  logic ptr = REQ_A;
  logic winA, winB;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h",
                  name, act, exp);
  endtask

  // Reference model: sweep countdown plus a "who goes next" pointer.
  always @(negedge clk) begin
    #1;
    if (rst) begin
      check("rstReady", {readyA, readyB}, 2'b00);
      check("rstBusy", busy, 1);
      sweepLeft = NR;
      sweepIdx  = 0;
      ptr       = REQ_A;
    end else if (sweepLeft > 0) begin
      check("sweepReady", {readyA, readyB}, 2'b00);
      check("sweepBusy", busy, 1);
      expQ.push_back({3'(sweepIdx), 8'h00});
      sweepIdx++;
      sweepLeft--;
    end else begin
      check("runBusy", busy, 0);
      winA = !clearReq && validA && (!validB || ptr == REQ_A);
      winB = !clearReq && validB && (!validA || ptr == REQ_B);
      check("grant", {readyA, readyB}, {winA, winB});
      if (clearReq) begin
        sweepLeft = NR;
        sweepIdx  = 0;
      end else if (winA) begin
        expQ.push_back({regA, dataA});
        ptr = REQ_B;
      end else if (winB) begin
        expQ.push_back({regB, dataB});
        ptr = REQ_A;
      end
    end
  end

  // Monitor: every bank write must match the oldest expected one.
  always @(negedge clk) begin
    if (regWrite === 1'b1) begin
      nWrites++;
      if (expQ.size() == 0) begin
        nChecks++;
        $display("FAIL unexpectedWrite: got R%0d=0x%0h, required none",
                 writeRegister, writeData);
      end else begin
        expW = expQ.pop_front();
        check("write", {writeRegister, writeData}, expW);
      end
      bank[writeRegister] = writeData;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    repeat (2) tick();
  endtask

  task automatic waitIdle(output int n);
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic checkBankZero(input string name);
    for (int i = 0; i < NR; i++) check(name, bank[i], 0);
  endtask

  task automatic issue(input logic vA, input logic [2:0] rA,
                       input logic [7:0] dA,
                       input logic vB, input logic [2:0] rB,
                       input logic [7:0] dB);
    logic pA, pB;
    int   g;
    validA = vA; regA = rA; dataA = dA;
    validB = vB; regB = rB; dataB = dB;
    pA = vA; pB = vB; g = 0;
    while ((pA || pB) && g < 20) begin
      @(negedge clk);
      if (validA && readyA) pA = 0;
      if (validB && readyB) pB = 0;
      tick();
      if (!pA) validA = 0;
      if (!pB) validB = 0;
      g++;
    end
    if (g >= 20) check("issueTimeout", g, 0);
  endtask

  task automatic traffic(input int cycles, input int clrPct);
    logic doneA, doneB;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      doneA = validA && readyA;
      doneB = validB && readyB;
      tick();
      if (!validA || doneA) begin
        validA = ($urandom_range(0, 99) < 60);
        regA   = 3'($urandom);
        dataA  = 8'($urandom);
      end
      if (!validB || doneB) begin
        validB = ($urandom_range(0, 99) < 60);
        regB   = 3'($urandom);
        dataB  = 8'($urandom);
      end
      clearReq = ($urandom_range(0, 99) < clrPct);
    end
    validA = 0; validB = 0; clearReq = 0;
  endtask

  int n, w0;

  initial begin
    rst = 1; validA = 0; validB = 0; clearReq = 0;
    regA = 0; regB = 0; dataA = 0; dataB = 0;
    rst2 = 1; validA2 = 0; regA2 = 0; dataA2 = 0;

    repeat (2) tick();
    check("rstRegWrite", regWrite, 0);
    check("rstWrReg", writeRegister, 0);
    check("rstWrData", writeData, 0);
    rst = 0;
    waitIdle(n);
    check("initBusyLen", n, NR);
    tick();
    checkBankZero("initZero");

    issue(1, 3'd1, 8'h11, 1, 3'd2, 8'h22);
    issue(1, 3'd0, 8'h01, 1, 3'd7, 8'h07);
    settle();
    check("contR1", bank[1], 8'h11);
    check("contR2", bank[2], 8'h22);
    check("contR0", bank[0], 8'h01);
    check("contR7", bank[7], 8'h07);

    w0 = nWrites;
    issue(1, 3'd4, 8'hAA, 1, 3'd4, 8'hBB);
    settle();
    check("sameDstR4", bank[4], 8'hBB);
    check("sameDstPulses", nWrites - w0, 2);

    validA = 1; regA = 3'd3; dataA = 8'h5A;
    #1;
    check("singleReady", readyA, 1);
    tick();
    validA = 0;
    check("singleWe", regWrite, 1);
    check("singleReg", writeRegister, 3);
    check("singleData", writeData, 8'h5A);
    settle();
    check("singleR3", bank[3], 8'h5A);

    issue(1, 3'd6, 8'h77, 0, 3'd0, 8'h00);
    settle();
    check("preClrR6", bank[6], 8'h77);
    validB = 1; regB = 3'd5; dataB = 8'h42; clearReq = 1;
    @(negedge clk);
    check("clrReadyB", readyB, 0);
    tick();
    clearReq = 0;
    n = 1;
    while (n < 30) begin
      @(negedge clk);
      if (readyB) break;
      tick();
      n++;
    end
    check("clrGrantCycle", n, 9);
    tick();
    validB = 0;
    settle();
    check("clrR6", bank[6], 0);
    check("clrR5", bank[5], 8'h42);

    traffic(400, 3);
    waitIdle(n);
    settle();

    clearReq = 1;
    tick();
    clearReq = 0;
    n = 0;
    while (!(regWrite && writeRegister == 3'd4) && n < 20) begin
      tick();
      n++;
    end
    check("sweepReach4", writeRegister, 4);
    rst = 1;
    tick();
    check("abortRegWrite", regWrite, 0);
    rst = 0;
    waitIdle(n);
    check("restartBusyLen", n, NR);
    tick();
    checkBankZero("restartZero");

    check("noInitBusy", busy2, 0);
    tick();
    rst2 = 0; validA2 = 1; regA2 = 3'd2; dataA2 = 8'h3C;
    #1;
    check("noInitBusyRun", busy2, 0);
    check("noInitReadyA", readyA2, 1);
    tick();
    validA2 = 0;
    check("noInitWe", regWrite2, 1);
    check("noInitReg", writeRegister2, 2);
    check("noInitData", writeData2, 8'h3C);

    settle();
    check("queueEmpty", expQ.size(), 0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/regbank_write_arbiter.md
Name: regbank_write_arbiter

Overview:
- Owns the single write port of the 8x8 register bank and shares it between two writeback requesters: A (ALU result) and B (load/immediate).
- After reset, and again on command, it runs an init sequencer that writes zero to every register.
- Grants are round-robin under contention, with a valid/ready handshake.
- Drives the bank's regWrite, writeRegister and writeData directly from registers.

Parameters:
- DATA_W, 8, register data width.
- ADDR_W, 3, register index width.
- NUM_REGS, 8, registers swept by the init/clear sequence (must be 2**ADDR_W).
- INIT_ON_RESET, 1, 1 = run the zero sweep after reset; 0 = go straight to RUN.

Ports:
- clk  in  1  sole clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- validA  in  1  requester A has a write pending.
- regA  in  ADDR_W  destination register for A.
- dataA  in  DATA_W  write data for A.
- readyA  out  1  grant to A; transfer occurs when validA and readyA are both high at a posedge.
- validB  in  1  requester B has a write pending.
- regB  in  ADDR_W  destination register for B.
- dataB  in  DATA_W  write data for B.
- readyB  out  1  grant to B.
- clearReq  in  1  single-cycle pulse that requests a zero sweep.
- busy  out  1  high in INIT or CLEAR.
- regWrite  out  1  write enable to the bank.
- writeRegister  out  ADDR_W  bank write index.
- writeData  out  DATA_W  bank write data.

Behaviour:
- States:
  - INIT: post-reset zero sweep.
  - RUN: arbitration.
  - CLEAR: commanded zero sweep.
- Reset (rst=1 at a posedge):
  - state goes to INIT if INIT_ON_RESET=1, else RUN.
  - sweep counter = 0; rrPtr = A.
  - regWrite = 0, writeRegister = 0, writeData = 0.
- While rst=1: readyA and readyB are forced 0, and busy is forced 1 when INIT_ON_RESET=1.
- Reset asserted mid-sweep or mid-write aborts the sweep or write. The regWrite register clears at the same edge; the bank sees no further writes.
- INIT and CLEAR sweeps:
  - Each cycle: register regWrite=1, writeRegister=counter, writeData=0, then counter+1.
  - After the write for index NUM_REGS-1 is registered, go to RUN and clear the counter.
  - Exactly NUM_REGS consecutive write cycles, in ascending order.
  - readyA = readyB = 0 throughout; busy = 1.
- RUN arbitration (ready is combinational from valids, state and rrPtr):
  - Only validA: readyA=1. Only validB: readyB=1.
  - Both valid: grant the requester named by rrPtr.
  - Neither valid: no grant.
  - Never both readys high at once.
- rrPtr update:
  - On any granted transfer, rrPtr moves to the other requester, so the loser of a contention wins next time.
  - With no transfer, rrPtr holds.
- Write latency: a transfer accepted at edge t produces regWrite=1, writeRegister=reg, writeData=data during cycle t..t+1. The bank commits at edge t+1.
- With no transfer in a RUN cycle, regWrite is registered 0. writeRegister and writeData hold their previous values.
- Back-to-back: one write per cycle sustained. Alternating A/B under continuous contention gives a strict A,B,A,B order from reset.
- Same destination from A and B in the same cycle: serialised. The later-granted write wins in the bank.
- clearReq:
  - Sampled only in RUN.
  - When high, no grant is issued that cycle (readyA = readyB = 0). Next state is CLEAR.
  - A write accepted on the previous edge still completes first.
  - clearReq in INIT or CLEAR is ignored; it is not queued.
- Requesters must hold valid, reg and data stable until their ready is seen. The arbiter does not buffer or check this.
- Register 0 is not protected; writes to index 0 pass through.

Decomposition:
- Shared package (regbank_pkg):
  - DATA_W and ADDR_W constants.
  - State encoding: ST_INIT, ST_RUN, ST_CLEAR.
  - Requester id constants: REQ_A, REQ_B.
- One sub-module is natural: rr_arbiter2. It is a 2-way round-robin grant with pointer update, taking valids and an accept strobe and producing one-hot grants. The sweep counter and FSM stay in the top.

Test Plan:
- Reset sweep: rst high 2 cycles, then low.
  - Required: busy=1 and regWrite=1 with writeRegister 0..7 on 8 consecutive cycles, writeData=0.
  - Then busy=0, and the bank reads all zeros.
- Single requester:
  - Stimulus: validA with regA=3, dataA=0x5A for 1 cycle in RUN.
  - Required: readyA=1 the same cycle; next cycle regWrite=1, writeRegister=3, writeData=0x5A; the bank's R3 reads 0x5A after the following edge.
- Contention:
  - Stimulus: A (reg1, 0x11) and B (reg2, 0x22) both held valid from the first RUN cycle.
  - Required: grants are A, then B on consecutive cycles; R1=0x11 and R2=0x22.
  - Continued contention alternates strictly.
- Same destination:
  - Stimulus: A (reg4, 0xAA) and B (reg4, 0xBB) simultaneously, with rrPtr=A.
  - Required: R4 ends 0xBB; two regWrite pulses.
- clearReq mid-traffic:
  - Stimulus: write 0x77 to R6, then pulse clearReq while validB is high.
  - Required: readyB=0 in the clearReq cycle; 8-cycle sweep with busy=1; R6=0.
  - B is granted on the first RUN cycle after the sweep.
- Reset mid-sweep:
  - Stimulus: assert rst at sweep index 4.
  - Required: at the next edge, regWrite=0 and the sweep restarts at index 0 once rst drops.
  - Repeat with INIT_ON_RESET=0: busy stays 0 and readyA responds on the first cycle after reset.
